// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Main control FSM for the multicycle RV32I core
module multicycle_ctrl #(
    parameter int unsigned RESET_STATE_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       reg_we,
    output logic [2:0] imm_sel,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic [1:0] alu_op,
    output logic [1:0] res_sel,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_LUI    = 4'd12,
        S_AUIPC  = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [3:0] HOLD_INIT = 4'(RESET_STATE_HOLD);

    state_t     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       phase_q, phase_d;
    logic       post_rst_q, post_rst_d;
    logic       fetch_go;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            hold_q     <= HOLD_INIT;
            phase_q    <= 1'b0;
            post_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            phase_q    <= phase_d;
            post_rst_q <= post_rst_d;
        end
    end

    // The cycle right after reset is blanked; the hold counter runs concurrently.
    assign fetch_go = (hold_q == 4'd0) && !post_rst_q;
    assign state    = state_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        phase_d      = phase_q;
        post_rst_d   = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        reg_we       = 1'b0;
        imm_sel      = IMM_I;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 2'd0;
        alu_op       = 2'b00;
        res_sel      = 2'd0;
        retire       = 1'b0;
        trap         = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end
                if (fetch_go) begin
                    mem_req   = 1'b1;
                    alu_a_sel = 2'd3;
                    alu_b_sel = 2'd2;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                // Branch/jump target is precomputed here into the ALU result register.
                alu_a_sel = 2'd1;
                alu_b_sel = 2'd1;
                imm_sel   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_b_sel = 2'd1;
                imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_we  = 1'b1;
                res_sel = 2'd1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_b_sel = 2'd1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_op  = 2'b01;
                pc_src  = 1'b1;
                pc_we   = branch_taken;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                alu_a_sel = 2'd1;
                alu_b_sel = 2'd2;
                reg_we    = 1'b1;
                res_sel   = 2'd2;
                pc_we     = 1'b1;
                pc_src    = 1'b1;
                imm_sel   = IMM_J;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JALR: begin
                // Phase 0 latches rs1+imm; phase 1 links old_pc+4 and jumps.
                if (!phase_q) begin
                    alu_b_sel = 2'd1;
                    phase_d   = 1'b1;
                end else begin
                    alu_a_sel = 2'd1;
                    alu_b_sel = 2'd2;
                    reg_we    = 1'b1;
                    res_sel   = 2'd2;
                    pc_we     = 1'b1;
                    pc_src    = 1'b1;
                    retire    = 1'b1;
                    phase_d   = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_LUI: begin
                alu_a_sel = 2'd2;
                alu_b_sel = 2'd1;
                imm_sel   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_a_sel = 2'd1;
                alu_b_sel = 2'd1;
                imm_sel   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (!rst_n || post_rst_q) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = 1'b0;
            reg_we       = 1'b0;
            imm_sel      = IMM_I;
            alu_a_sel    = 2'd0;
            alu_b_sel    = 2'd0;
            alu_op       = 2'b00;
            res_sel      = 2'd0;
            retire       = 1'b0;
            trap         = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - Self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we;
    logic [2:0] imm_sel;
    logic [1:0] alu_a_sel, alu_b_sel, alu_op, res_sel;
    logic       retire, trap;
    logic [3:0] state;

    multicycle_ctrl #(.RESET_STATE_HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .imm_sel(imm_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_op(alu_op), .res_sel(res_sel), .retire(retire), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef struct {
        string      tag;
        logic       rst;
        logic [6:0] op;
        logic       rdy;
        logic       bt;
        logic       chk;
        logic [23:0] exp;
    } step_t;

    step_t sb_q[$];
    int    errors = 0;
    int    checks = 0;

    logic [23:0] obs;
    assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we,
                  imm_sel, alu_a_sel, alu_b_sel, alu_op, res_sel, retire, trap};

    logic [19:0] zero, f_go, f_wait, dec_b, dec_j, aluwb, exec_i, memadr_l, memrd, memwb;

    function automatic logic [19:0] ctl(input logic req, we, mas, irwe, pcwe, pcsrc, regwe,
                                        input logic [2:0] imm, input logic [1:0] a, b, op, res,
                                        input logic ret, trp);
        return {req, we, mas, irwe, pcwe, pcsrc, regwe, imm, a, b, op, res, ret, trp};
    endfunction

    task automatic push(input string tag, input logic rst, input logic [6:0] op, input logic rdy,
                        input logic bt, input logic chk, input logic [3:0] st, input logic [19:0] c);
        step_t s;
        s.tag = tag; s.rst = rst; s.op = op; s.rdy = rdy; s.bt = bt; s.chk = chk; s.exp = {st, c};
        sb_q.push_back(s);
    endtask

    task automatic expect_step(input string tag, input logic [6:0] op, input logic rdy,
                               input logic bt, input logic [3:0] st, input logic [19:0] c);
        push(tag, 1'b1, op, rdy, bt, 1'b1, st, c);
    endtask

    // Drive the next queued stimulus at negedge and return the sampled outputs.
    task automatic next_step(output step_t s, output logic [23:0] o);
        s = sb_q.pop_front();
        @(negedge clk);
        rst_n = s.rst; opcode = s.op; mem_ready = s.rdy; branch_taken = s.bt;
        #1;
        o = obs;
    endtask

    task automatic test_reset;
        step_t s; logic [23:0] o;
        push("rst0", 1'b0, OP_I, 1'b1, 1'b0, 1'b1, 4'd0, zero);
        push("rst1", 1'b0, OP_I, 1'b1, 1'b0, 1'b1, 4'd0, zero);
        expect_step("hold0", OP_I, 1'b1, 1'b0, 4'd0, zero);
        expect_step("hold1", OP_I, 1'b1, 1'b0, 4'd0, zero);
        expect_step("fetch", OP_I, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("decode", OP_I, 1'b1, 1'b0, 4'd1, dec_b);
        expect_step("exec_i", OP_I, 1'b1, 1'b0, 4'd7, exec_i);
        expect_step("aluwb", OP_I, 1'b1, 1'b0, 4'd8, aluwb);
        while (sb_q.size() > 0) begin
            next_step(s, o);
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL reset/%s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         s.tag, o[23:20], o[19:0], s.exp[23:20], s.exp[19:0]);
            end
        end
    endtask

    task automatic test_addi;
        step_t s; logic [23:0] o; int n_we, n_ret;
        n_we = 0; n_ret = 0;
        expect_step("fetch", OP_I, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("decode", OP_I, 1'b1, 1'b0, 4'd1, dec_b);
        expect_step("exec_i", OP_I, 1'b1, 1'b0, 4'd7, exec_i);
        expect_step("aluwb", OP_I, 1'b1, 1'b0, 4'd8, aluwb);
        while (sb_q.size() > 0) begin
            next_step(s, o);
            n_we += int'(reg_we); n_ret += int'(retire);
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL addi/%s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         s.tag, o[23:20], o[19:0], s.exp[23:20], s.exp[19:0]);
            end
        end
        checks++;
        if (n_we != 1 || n_ret != 1) begin
            errors++;
            $display("FAIL addi/pulses: got reg_we=%0d retire=%0d, expected 1 and 1", n_we, n_ret);
        end
    endtask

    task automatic test_load_stall;
        step_t s; logic [23:0] o; int n_req;
        n_req = 0;
        expect_step("fetch", OP_LOAD, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("decode", OP_LOAD, 1'b1, 1'b0, 4'd1, dec_b);
        expect_step("memadr", OP_LOAD, 1'b1, 1'b0, 4'd2, memadr_l);
        for (int i = 0; i < 3; i++) expect_step("memrd_wait", OP_LOAD, 1'b0, 1'b0, 4'd3, memrd);
        expect_step("memrd_done", OP_LOAD, 1'b1, 1'b0, 4'd3, memrd);
        expect_step("memwb", OP_LOAD, 1'b1, 1'b0, 4'd4, memwb);
        while (sb_q.size() > 0) begin
            next_step(s, o);
            if (mem_req && mem_addr_sel && !mem_we) n_req++;
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL load/%s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         s.tag, o[23:20], o[19:0], s.exp[23:20], s.exp[19:0]);
            end
        end
        checks++;
        if (n_req != 4) begin
            errors++;
            $display("FAIL load/req_cycles: got %0d, expected 4", n_req);
        end
    endtask

    task automatic test_branch;
        step_t s; logic [23:0] o;
        for (int t = 0; t < 2; t++) begin
            // branch_taken is driven inverted outside BRANCH so only that cycle may matter
            expect_step("fetch", OP_BRANCH, 1'b1, !t[0], 4'd0, f_go);
            expect_step("decode", OP_BRANCH, 1'b1, !t[0], 4'd1, dec_b);
            expect_step(t[0] ? "taken" : "not_taken", OP_BRANCH, 1'b1, t[0], 4'd9,
                        ctl(0, 0, 0, 0, t[0], 1, 0, 3'd0, 2'd0, 2'd0, 2'b01, 2'd0, 1, 0));
        end
        while (sb_q.size() > 0) begin
            next_step(s, o);
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL branch/%s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         s.tag, o[23:20], o[19:0], s.exp[23:20], s.exp[19:0]);
            end
        end
    endtask

    task automatic test_jal_jalr;
        step_t s; logic [23:0] o;
        expect_step("jal_fetch", OP_JAL, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("jal_decode", OP_JAL, 1'b1, 1'b0, 4'd1, dec_j);
        expect_step("jal_exec", OP_JAL, 1'b1, 1'b0, 4'd10,
                    ctl(0, 0, 0, 0, 1, 1, 1, 3'b100, 2'd1, 2'd2, 2'b00, 2'd2, 1, 0));
        expect_step("jalr_fetch", OP_JALR, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("jalr_decode", OP_JALR, 1'b1, 1'b0, 4'd1, dec_b);
        expect_step("jalr_c1", OP_JALR, 1'b1, 1'b0, 4'd11,
                    ctl(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'd0, 2'd1, 2'b00, 2'd0, 0, 0));
        expect_step("jalr_c2", OP_JALR, 1'b1, 1'b0, 4'd11,
                    ctl(0, 0, 0, 0, 1, 1, 1, 3'b000, 2'd1, 2'd2, 2'b00, 2'd2, 1, 0));
        while (sb_q.size() > 0) begin
            next_step(s, o);
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL jump/%s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         s.tag, o[23:20], o[19:0], s.exp[23:20], s.exp[19:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        step_t s; logic [23:0] o;
        expect_step("r_fetch", OP_R, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("r_decode", OP_R, 1'b1, 1'b0, 4'd1, dec_b);
        expect_step("r_exec", OP_R, 1'b1, 1'b0, 4'd6,
                    ctl(0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 2'b10, 2'd0, 0, 0));
        expect_step("r_wb", OP_R, 1'b1, 1'b0, 4'd8, aluwb);
        expect_step("lui_fetch", OP_LUI, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("lui_decode", OP_LUI, 1'b1, 1'b0, 4'd1, dec_b);
        expect_step("lui_exec", OP_LUI, 1'b1, 1'b0, 4'd12,
                    ctl(0, 0, 0, 0, 0, 0, 0, 3'b011, 2'd2, 2'd1, 2'b00, 2'd0, 0, 0));
        expect_step("lui_wb", OP_LUI, 1'b1, 1'b0, 4'd8, aluwb);
        expect_step("auipc_fetch", OP_AUIPC, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("auipc_decode", OP_AUIPC, 1'b1, 1'b0, 4'd1, dec_b);
        expect_step("auipc_exec", OP_AUIPC, 1'b1, 1'b0, 4'd13,
                    ctl(0, 0, 0, 0, 0, 0, 0, 3'b011, 2'd1, 2'd1, 2'b00, 2'd0, 0, 0));
        expect_step("auipc_wb", OP_AUIPC, 1'b1, 1'b0, 4'd8, aluwb);
        expect_step("sw_fetch_wait", OP_STORE, 1'b0, 1'b0, 4'd0, f_wait);
        expect_step("sw_fetch_wait", OP_STORE, 1'b0, 1'b0, 4'd0, f_wait);
        expect_step("sw_fetch", OP_STORE, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("sw_decode", OP_STORE, 1'b1, 1'b0, 4'd1, dec_b);
        expect_step("sw_memadr", OP_STORE, 1'b1, 1'b0, 4'd2,
                    ctl(0, 0, 0, 0, 0, 0, 0, 3'b001, 2'd0, 2'd1, 2'b00, 2'd0, 0, 0));
        expect_step("sw_wait", OP_STORE, 1'b0, 1'b0, 4'd5,
                    ctl(1, 1, 1, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 2'b00, 2'd0, 0, 0));
        expect_step("sw_done", OP_STORE, 1'b1, 1'b0, 4'd5,
                    ctl(1, 1, 1, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 2'b00, 2'd0, 1, 0));
        expect_step("jalr2_fetch", OP_JALR, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("jalr2_decode", OP_JALR, 1'b1, 1'b0, 4'd1, dec_b);
        expect_step("jalr2_c1", OP_JALR, 1'b1, 1'b0, 4'd11,
                    ctl(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'd0, 2'd1, 2'b00, 2'd0, 0, 0));
        expect_step("jalr2_c2", OP_JALR, 1'b1, 1'b0, 4'd11,
                    ctl(0, 0, 0, 0, 1, 1, 1, 3'b000, 2'd1, 2'd2, 2'b00, 2'd2, 1, 0));
        while (sb_q.size() > 0) begin
            next_step(s, o);
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL b2b/%s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         s.tag, o[23:20], o[19:0], s.exp[23:20], s.exp[19:0]);
            end
        end
    endtask

    task automatic test_reset_mid_request;
        step_t s; logic [23:0] o;
        expect_step("fetch", OP_LOAD, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("decode", OP_LOAD, 1'b1, 1'b0, 4'd1, dec_b);
        expect_step("memadr", OP_LOAD, 1'b1, 1'b0, 4'd2, memadr_l);
        expect_step("memrd_wait", OP_LOAD, 1'b0, 1'b0, 4'd3, memrd);
        push("reset", 1'b0, OP_LOAD, 1'b1, 1'b0, 1'b0, 4'd0, zero);
        expect_step("after0", OP_LOAD, 1'b1, 1'b0, 4'd0, zero);
        expect_step("after1", OP_LOAD, 1'b1, 1'b0, 4'd0, zero);
        expect_step("refetch_wait", OP_LOAD, 1'b0, 1'b0, 4'd0, f_wait);
        while (sb_q.size() > 0) begin
            next_step(s, o);
            if (s.chk) begin
                checks++;
                if (o !== s.exp) begin
                    errors++;
                    $display("FAIL midreset/%s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                             s.tag, o[23:20], o[19:0], s.exp[23:20], s.exp[19:0]);
                end
            end
        end
    endtask

    task automatic test_trap;
        step_t s; logic [23:0] o;
        expect_step("fetch", OP_BAD, 1'b1, 1'b0, 4'd0, f_go);
        expect_step("decode", OP_BAD, 1'b1, 1'b0, 4'd1, dec_b);
        for (int i = 0; i < 20; i++)
            expect_step("trapped", OP_BAD, 1'($urandom_range(0, 1)), 1'b0, 4'd14,
                        ctl(0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 2'b00, 2'd0, 0, 1));
        push("reset", 1'b0, OP_BAD, 1'b0, 1'b0, 1'b0, 4'd0, zero);
        expect_step("cleared", OP_I, 1'b1, 1'b0, 4'd0, zero);
        expect_step("hold", OP_I, 1'b1, 1'b0, 4'd0, zero);
        expect_step("refetch", OP_I, 1'b1, 1'b0, 4'd0, f_go);
        while (sb_q.size() > 0) begin
            next_step(s, o);
            if (s.chk) begin
                checks++;
                if (o !== s.exp) begin
                    errors++;
                    $display("FAIL trap/%s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                             s.tag, o[23:20], o[19:0], s.exp[23:20], s.exp[19:0]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        zero     = 20'd0;
        f_go     = ctl(1, 0, 0, 1, 1, 0, 0, 3'd0, 2'd3, 2'd2, 2'b00, 2'd0, 0, 0);
        f_wait   = ctl(1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd3, 2'd2, 2'b00, 2'd0, 0, 0);
        dec_b    = ctl(0, 0, 0, 0, 0, 0, 0, 3'b010, 2'd1, 2'd1, 2'b00, 2'd0, 0, 0);
        dec_j    = ctl(0, 0, 0, 0, 0, 0, 0, 3'b100, 2'd1, 2'd1, 2'b00, 2'd0, 0, 0);
        exec_i   = ctl(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'd0, 2'd1, 2'b10, 2'd0, 0, 0);
        aluwb    = ctl(0, 0, 0, 0, 0, 0, 1, 3'd0, 2'd0, 2'd0, 2'b00, 2'd0, 1, 0);
        memadr_l = ctl(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'd0, 2'd1, 2'b00, 2'd0, 0, 0);
        memrd    = ctl(1, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 2'b00, 2'd0, 0, 0);
        memwb    = ctl(0, 0, 0, 0, 0, 0, 1, 3'd0, 2'd0, 2'd0, 2'b00, 2'd1, 1, 0);

        test_reset();
        test_addi();
        test_load_stall();
        test_branch();
        test_jal_jalr();
        test_back_to_back();
        test_reset_mid_request();
        test_trap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback over shared resources: one ALU, one unified memory port, the register file and the immediate generator.
- Decodes the opcode of the latched instruction and drives every datapath select and write enable, including the 3-bit immediate-format select used by the immediate generator.
- Stalls on a ready/request memory handshake.
- Traps on illegal opcodes.

Parameters:
RESET_STATE_HOLD, 0, number of extra cycles held in FETCH with mem_req low after reset release (0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
opcode  input  7  instr[6:0] from the instruction register
mem_ready  input  1  memory completes the current request this cycle
branch_taken  input  1  comparator result for current branch (funct3 already applied)
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  request is a store
mem_addr_sel  output  1  0 = PC, 1 = ALU result register
ir_we  output  1  latch instruction and old_pc
pc_we  output  1  write PC
pc_src  output  1  0 = ALU combinational result, 1 = ALU result register
reg_we  output  1  register file write
imm_sel  output  3  000 I, 001 S, 010 B, 011 U, 100 J
alu_a_sel  output  2  0 rs1, 1 old_pc, 2 zero, 3 PC
alu_b_sel  output  2  0 rs2, 1 imm32, 2 constant 4
alu_op  output  2  00 add, 01 sub, 10 funct-decoded
res_sel  output  2  0 ALU result register, 1 memory data register, 2 ALU combinational
retire  output  1  one-cycle pulse per completed instruction
trap  output  1  illegal opcode seen; sticky until reset
state  output  4  current state, for debug

Behaviour:
- **Reset** (rst_n low at a clk edge): state = FETCH, hold counter = RESET_STATE_HOLD, trap = 0. All outputs are 0 during and in the cycle after reset, except the state code.
- **Outputs:** Moore style, decoded from state only. Exception: ir_we and pc_we in FETCH also require mem_ready.
- **Defaults:** every enable is 0 and every select is 0 unless listed for a state.
- **State codes:**
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11
  - LUI 12, AUIPC 13, TRAP 14
- **FETCH:**
  - If the hold counter is nonzero: decrement it, mem_req = 0.
  - Otherwise: mem_req = 1, mem_addr_sel = 0, alu_a_sel = 3, alu_b_sel = 2, alu_op = 00.
  - On mem_ready: ir_we = 1, pc_we = 1, pc_src = 0, next state DECODE. Otherwise stay in FETCH.
- **DECODE:** alu_a_sel = 1, alu_b_sel = 1, imm_sel = 010 (precompute branch target into the ALU result register). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> TRAP
- **MEMADR:** alu_a_sel = 0, alu_b_sel = 1. imm_sel = 000 for loads, 001 for stores. Next state MEMRD (load) or MEMWR (store).
- **MEMRD:** mem_req = 1, mem_addr_sel = 1. On mem_ready go to MEMWB; otherwise stay.
- **MEMWB:** reg_we = 1, res_sel = 1, retire = 1, next state FETCH.
- **MEMWR:** mem_req = 1, mem_we = 1, mem_addr_sel = 1. On mem_ready: retire = 1, next state FETCH.
- **EXEC_R:** alu_a_sel = 0, alu_b_sel = 0, alu_op = 10, next state ALUWB.
- **EXEC_I:** alu_a_sel = 0, alu_b_sel = 1, imm_sel = 000, alu_op = 10, next state ALUWB.
- **ALUWB:** reg_we = 1, res_sel = 0, retire = 1, next state FETCH.
- **BRANCH:**
  - alu_a_sel = 0, alu_b_sel = 0, alu_op = 01, pc_src = 1.
  - pc_we = branch_taken, sampled in this cycle only.
  - retire = 1, next state FETCH.
- **JAL:**
  - Datapath: alu_a_sel = 1, alu_b_sel = 2 (old_pc + 4 on the ALU output), reg_we = 1, res_sel = 2.
  - PC update: pc_we = 1, pc_src = 1, where the register holds the DECODE target. imm_sel = 100.
  - Note: DECODE always precomputes a B-format target. For JAL, DECODE instead uses imm_sel = 100; imm_sel in DECODE is therefore 100 when opcode = 1101111, else 010.
  - retire = 1, next state FETCH.
- **JALR:** two cycles.
  - Cycle 1: alu_a_sel = 0, alu_b_sel = 1, imm_sel = 000. Result is latched into the ALU result register. Next state ALUWB-like.
  - Cycle 2 is encoded within JALR using an internal 1-bit phase flag: reg_we = 1, res_sel = 2 with alu_a_sel = 1, alu_b_sel = 2; pc_we = 1, pc_src = 1; retire = 1, next state FETCH.
  - The phase flag clears on reset and on exit.
- **LUI:** alu_a_sel = 2, alu_b_sel = 1, imm_sel = 011, next state ALUWB.
- **AUIPC:** alu_a_sel = 1, alu_b_sel = 1, imm_sel = 011, next state ALUWB.
- **TRAP:** trap = 1. No enables asserted. Stays in TRAP until rst_n is low.
- **Stalls:** mem_req stays high and all other outputs stay stable while mem_ready is low, for any number of cycles.
- **Spurious mem_ready:** mem_ready while mem_req = 0 is ignored.
- **Reset mid-request:** reset during MEMRD/MEMWR/FETCH drops mem_req in the next cycle. No retire, no register write.

Test Plan:
- Reset, RESET_STATE_HOLD = 2, mem_ready = 1 -> mem_req low for 2 cycles after release, then FETCH with ir_we = pc_we = 1 in the same cycle.
- ADDI (opcode 0010011), mem_ready = 1 -> states 0,1,7,8,0. imm_sel = 000 in EXEC_I. Exactly one reg_we pulse and one retire pulse; 4 cycles total.
- LW with 3 wait cycles in MEMRD -> mem_req held 4 cycles with mem_addr_sel = 1 and mem_we = 0. MEMWB res_sel = 1. 5 + 3 = 8 cycles.
- BEQ: branch_taken = 0 -> no pc_we in BRANCH. Repeat with branch_taken = 1 -> pc_we = 1 and pc_src = 1. imm_sel = 010 in DECODE both times.
- JAL then JALR -> JAL: imm_sel = 100 in DECODE, reg_we and pc_we together in one cycle. JALR: 2-cycle execute, pc_we only in the second cycle.
- Opcode 1111111 -> TRAP (state 14), trap = 1, no mem_req for 20 cycles. rst_n low for one cycle -> FETCH, trap = 0.
